// File: rtl/lamp_pkg.sv
// lamp_pkg: shared definitions for the lamp ramp controller.
//   MODE_*  : display mode encodings carried on target_mode
//             (2'b11 is not listed and is shown as a bar).
//   state_t : ramp controller states.
package lamp_pkg;

   localparam logic [1:0] MODE_BAR   = 2'b00;
   localparam logic [1:0] MODE_DOT   = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_RAMP_DOWN = 2'd2
   } state_t;

endpackage

// File: rtl/lamp_ramp_ctrl_if.sv
// lamp_ramp_ctrl_if: count-request handshake between the panel control
// logic (master) and the lamp ramp controller (slave).
//   target_valid : master -> slave, request present
//   target_ready : slave -> master, request can be accepted this cycle
//   target_count : master -> slave, requested number of active lamps
//   target_mode  : master -> slave, display mode (see lamp_pkg)
// A transfer happens on a clock edge where target_valid && target_ready.
interface lamp_ramp_ctrl_if #(
   parameter int CNT_W = 5
) ();

   logic             target_valid;
   logic             target_ready;
   logic [CNT_W-1:0] target_count;
   logic [1:0]       target_mode;

   modport master (
      output target_valid,
      output target_count,
      output target_mode,
      input  target_ready
   );

   modport slave (
      input  target_valid,
      input  target_count,
      input  target_mode,
      output target_ready
   );

endinterface

// File: rtl/lamp_ramp_ctrl_decode.sv
// lamp_decode: combinational count-to-lamp-pattern decoder.
//   count    : number of active lamps (0..N_LAMPS)
//   mode     : display mode (bar / dot / blink-bar, 2'b11 shown as bar)
//   blink_on : blink phase, 1 = ON
//   pattern  : lamp pattern, bit 0 = lamp 0
// Bar lights the low `count` lamps, dot lights only lamp count-1
// (nothing for count 0), blink-bar is the bar gated by the blink phase.
module lamp_decode
   import lamp_pkg::*;
#(
   parameter int N_LAMPS = 16,
   parameter int CNT_W   = $clog2(N_LAMPS + 1)
) (
   input  logic [CNT_W-1:0]   count,
   input  logic [1:0]         mode,
   input  logic               blink_on,
   output logic [N_LAMPS-1:0] pattern
);

   logic [N_LAMPS-1:0] bar;
   logic [N_LAMPS-1:0] dot;

   always_comb begin
      bar = '0;
      dot = '0;
      for (int unsigned i = 0; i < N_LAMPS; i++) begin
         bar[i] = (CNT_W'(i) < count);
         dot[i] = (CNT_W'(i + 1) == count);
      end
   end

   always_comb begin
      pattern = bar;
      case (mode)
         MODE_DOT:   pattern = dot;
         MODE_BLINK: pattern = blink_on ? bar : '0;
         default:    pattern = bar;
      endcase
   end

endmodule

// File: rtl/lamp_ramp_ctrl.sv
// lamp_ramp_ctrl: drives N_LAMPS lamps from a requested active-lamp count,
// ramping one lamp per STEP_DIV cycles toward the request.
//   clk           : system clock
//   reset         : synchronous, active-high
//   bus (slave)   : target_valid/target_ready/target_count/target_mode
//                   request handshake; ready only while idle
//   lights_state  : registered lamp drive, bit 0 = lamp 0
//   current_count : registered displayed count
//   busy          : high while ramping
// Requests above N_LAMPS saturate. A request equal to the displayed count
// only updates the mode. The blink phase free-runs from reset, toggling
// every BLINK_DIV cycles.
module lamp_ramp_ctrl
   import lamp_pkg::*;
#(
   parameter int N_LAMPS   = 16,
   parameter int CNT_W     = $clog2(N_LAMPS + 1),
   parameter int STEP_DIV  = 4,
   parameter int BLINK_DIV = 8
) (
   input  logic               clk,
   input  logic               reset,
   lamp_ramp_ctrl_if.slave    bus,
   output logic [N_LAMPS-1:0] lights_state,
   output logic [CNT_W-1:0]   current_count,
   output logic               busy
);

   localparam int PS_W = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;
   localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(STEP_DIV - 1);
   localparam logic [BL_W-1:0]  BL_MAX  = BL_W'(BLINK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_LAMPS);

   state_t             state;
   state_t             state_n;
   logic [CNT_W-1:0]   tgt;
   logic [CNT_W-1:0]   tgt_n;
   logic [CNT_W-1:0]   cnt_n;
   logic [CNT_W-1:0]   req_sat;
   logic [1:0]         mode;
   logic [1:0]         mode_n;
   logic [PS_W-1:0]    presc;
   logic [PS_W-1:0]    presc_n;
   logic [BL_W-1:0]    blink_cnt;
   logic [BL_W-1:0]    blink_cnt_n;
   logic               blink_on;
   logic               blink_on_n;
   logic [N_LAMPS-1:0] pattern_n;

   assign bus.target_ready = (state == ST_IDLE);

   assign req_sat = (bus.target_count > CNT_MAX) ? CNT_MAX : bus.target_count;

   // Ramp FSM and prescaler.
   always_comb begin
      state_n = state;
      tgt_n   = tgt;
      cnt_n   = current_count;
      mode_n  = mode;
      presc_n = presc;
      case (state)
         ST_IDLE: begin
            if (bus.target_valid) begin
               mode_n  = bus.target_mode;
               tgt_n   = req_sat;
               presc_n = '0;
               if (req_sat > current_count) begin
                  state_n = ST_RAMP_UP;
               end else if (req_sat < current_count) begin
                  state_n = ST_RAMP_DOWN;
               end
            end
         end
         ST_RAMP_UP, ST_RAMP_DOWN: begin
            if (presc == PS_MAX) begin
               presc_n = '0;
               cnt_n   = (state == ST_RAMP_UP) ? current_count + CNT_W'(1)
                                               : current_count - CNT_W'(1);
               if (cnt_n == tgt) begin
                  state_n = ST_IDLE;
               end
            end else begin
               presc_n = presc + PS_W'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Free-running blink phase, independent of the ramp.
   always_comb begin
      blink_cnt_n = blink_cnt + BL_W'(1);
      blink_on_n  = blink_on;
      if (blink_cnt == BL_MAX) begin
         blink_cnt_n = '0;
         blink_on_n  = ~blink_on;
      end
   end

   // Decoding the next-state count/mode/phase keeps lights_state in step
   // with current_count instead of one cycle behind it.
   lamp_decode #(
      .N_LAMPS (N_LAMPS),
      .CNT_W   (CNT_W)
   ) u_decode (
      .count    (cnt_n),
      .mode     (mode_n),
      .blink_on (blink_on_n),
      .pattern  (pattern_n)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         tgt           <= '0;
         current_count <= '0;
         mode          <= MODE_BAR;
         presc         <= '0;
         blink_cnt     <= '0;
         blink_on      <= 1'b1;
         lights_state  <= '0;
         busy          <= 1'b0;
      end else begin
         state         <= state_n;
         tgt           <= tgt_n;
         current_count <= cnt_n;
         mode          <= mode_n;
         presc         <= presc_n;
         blink_cnt     <= blink_cnt_n;
         blink_on      <= blink_on_n;
         lights_state  <= pattern_n;
         busy          <= (state_n != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_lamp_ramp_ctrl.sv
// tb_lamp_ramp_ctrl: scoreboard bench for lamp_ramp_ctrl
// (N_LAMPS=16, STEP_DIV=4, BLINK_DIV=8). A reference model pushes the
// expected outputs after every clock edge; a monitor pops them on the
// falling edge and compares against the DUT.
module tb_lamp_ramp_ctrl;

   localparam int N     = 16;
   localparam int CW    = 5;
   localparam int STEP  = 4;
   localparam int BLINK = 8;

   logic          clk;
   logic          reset;
   logic [N-1:0]  lights_state;
   logic [CW-1:0] current_count;
   logic          busy;

   lamp_ramp_ctrl_if #(.CNT_W(CW)) bus ();

   lamp_ramp_ctrl #(
      .N_LAMPS   (N),
      .CNT_W     (CW),
      .STEP_DIV  (STEP),
      .BLINK_DIV (BLINK)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus.slave),
      .lights_state  (lights_state),
      .current_count (current_count),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int cnt;
      int lights;
      bit busy;
      bit ready;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: each accepted request is remembered as a start
   // count, target, accept edge and finish edge; outputs at any later edge
   // follow from elapsed time by plain arithmetic.
   int  edge_n   = 0;
   bit  m_on     = 0;
   int  m_c0, m_tgt, m_t0, m_end, m_mode, m_blink0;
   int  m_req, m_d, m_steps, m_cnt, m_pat;
   exp_t m_e;

   function automatic int bar_of(input int c);
      longint one;
      one = 1;
      return int'((one << c) - 1);
   endfunction

   always @(posedge clk) begin
      edge_n = edge_n + 1;
      if (reset) begin
         m_on     = 1;
         m_c0     = 0;
         m_tgt    = 0;
         m_t0     = edge_n;
         m_end    = edge_n;
         m_mode   = 0;
         m_blink0 = edge_n;
      end else if (m_on && bus.target_valid && edge_n > m_end) begin
         m_req  = int'(bus.target_count);
         if (m_req > N) m_req = N;
         m_c0   = m_tgt;
         m_tgt  = m_req;
         m_t0   = edge_n;
         m_end  = edge_n + ((m_tgt > m_c0) ? (m_tgt - m_c0) : (m_c0 - m_tgt)) * STEP;
         m_mode = int'(bus.target_mode);
      end
      if (m_on) begin
         m_d     = m_tgt - m_c0;
         m_steps = (edge_n - m_t0) / STEP;
         if (m_steps > ((m_d < 0) ? -m_d : m_d)) m_steps = (m_d < 0) ? -m_d : m_d;
         m_cnt   = (m_d >= 0) ? m_c0 + m_steps : m_c0 - m_steps;
         if (m_mode == 1)
            m_pat = (m_cnt == 0) ? 0 : (1 << (m_cnt - 1));
         else if (m_mode == 2 && (((edge_n - m_blink0) / BLINK) % 2) == 1)
            m_pat = 0;
         else
            m_pat = bar_of(m_cnt);
         m_e.cnt    = m_cnt;
         m_e.lights = m_pat;
         m_e.busy   = (edge_n < m_end);
         m_e.ready  = !(edge_n < m_end);
         exp_q.push_back(m_e);
      end
   end

   // Monitor: registered outputs are presented every cycle.
   exp_t mon_e;

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("current_count", int'(current_count), mon_e.cnt);
         check("lights_state", int'(lights_state), mon_e.lights);
         check("busy", int'(busy), int'(mon_e.busy));
         check("target_ready", int'(bus.target_ready), int'(mon_e.ready));
      end
   end

   // Stimulus.
   task automatic request(input int c, input int m);
      bus.target_valid = 1'b1;
      bus.target_count = CW'(c);
      bus.target_mode  = 2'(m);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (bus.target_ready) begin
            @(posedge clk);
            #1;
            bus.target_valid = 1'b0;
            return;
         end
      end
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL handshake_timeout: got no ready expected ready within 300 cycles");
      bus.target_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (bus.target_ready) return;
      end
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL idle_timeout: got busy expected idle within 300 cycles");
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset            = 1'b1;
      bus.target_valid = 1'b0;
      bus.target_count = '0;
      bus.target_mode  = '0;
      cycles(2);
      reset = 1'b0;
      cycles(1);

      // Ramp up 0 -> 3, bar.
      request(3, 0);
      wait_idle();
      // 10 then down to 8.
      request(10, 0);
      wait_idle();
      request(8, 0);
      wait_idle();
      // Saturating request.
      request(20, 0);
      wait_idle();
      cycles(2);
      // Mode-only change to dot at 5, then down to 0.
      request(5, 0);
      wait_idle();
      request(5, 1);
      cycles(3);
      request(0, 1);
      wait_idle();
      // Blink at 4, watch a few phases, then requests held while busy.
      request(4, 2);
      wait_idle();
      cycles(20);
      request(6, 2);
      request(2, 2);
      wait_idle();
      cycles(5);
      // Reset during a ramp to 9, with a simultaneous request.
      request(9, 0);
      cycles(9);
      reset            = 1'b1;
      bus.target_valid = 1'b1;
      bus.target_count = CW'(7);
      cycles(1);
      reset            = 1'b0;
      bus.target_valid = 1'b0;
      request(1, 0);
      wait_idle();

      // Randomized requests, modes, gaps and reset pulses.
      for (int r = 0; r < 40; r++) begin
         request(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) wait_idle();
         cycles(int'($urandom_range(0, 3)));
         if ($urandom_range(0, 9) == 0) cycles(int'($urandom_range(8, 20)));
         if ($urandom_range(0, 19) == 0) begin
            reset = 1'b1;
            cycles(1);
            reset = 1'b0;
         end
      end
      wait_idle();
      cycles(4);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
